mul_vector_initiator: RTL and testbench

Vector-driven request initiator for the shift-and-add multiplier responder. It holds a small table of operand/expected-result vectors and issues them one at a time over a valid/ready request channel. It then waits for each response, compares it against the expected value, and accumulates pass/fail statistics. It sits on the requesting side of the multiplier channel and replaces software-side stimulus when running standalone regressions.

---
 rtl/mul_vector_initiator.sv | 190 +++++++++++++++++++
 tb/tb_mul_vector_initiator.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_vector_initiator.sv
// mul_vector_initiator
// Replays a table of operand/expected-result vectors against the
// shift-and-add multiplier responder over a valid/ready request channel,
// checks every response and accumulates per-run pass/fail statistics.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ld_en/ld_addr/ld_inp1/ld_inp2/ld_expect
//                            vector table write port (ignored while busy)
//   num_vectors, start       run length (clamped to DEPTH) and run trigger
//   req_valid/req_ready/req_inp1/req_inp2
//                            request channel to the responder
//   rsp_valid/rsp_result     response strobe and data
//   busy, done               run in progress, one-cycle completion pulse
//   pass_cnt, fail_cnt       per-run counters
//   first_fail_valid/first_fail_idx
//                            first failing vector of the run
module mul_vector_initiator #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned W       = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [W-1:0]  ld_inp1,
    input  logic [W-1:0]  ld_inp2,
    input  logic [W-1:0]  ld_expect,
    input  logic [AW:0]   num_vectors,
    input  logic          start,
    output logic          req_valid,
    input  logic          req_ready,
    output logic [W-1:0]  req_inp1,
    output logic [W-1:0]  req_inp2,
    input  logic          rsp_valid,
    input  logic [W-1:0]  rsp_result,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   pass_cnt,
    output logic [AW:0]   fail_cnt,
    output logic          first_fail_valid,
    output logic [AW-1:0] first_fail_idx
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] N_MAX  = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t        state;
    logic [W-1:0]  mem_a [DEPTH];
    logic [W-1:0]  mem_b [DEPTH];
    logic [W-1:0]  mem_e [DEPTH];
    logic [CW-1:0] n_vec;
    logic [CW-1:0] idx;
    logic [TW-1:0] timer;

    logic [CW-1:0] n_clamp;
    logic [CW-1:0] idx_nxt;
    logic [AW-1:0] slot;
    logic [AW-1:0] slot_nxt;
    logic          ld_hit0;
    logic [W-1:0]  first_a;
    logic [W-1:0]  first_b;
    logic          vec_end;
    logic          vec_fail;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (c == '1) ? c : c + CW'(1);
    endfunction

    // Table write port; contents survive reset and runs.
    always_ff @(posedge clk) begin
        if (ld_en && !busy && ({1'b0, ld_addr} < N_MAX)) begin
            mem_a[ld_addr] <= ld_inp1;
            mem_b[ld_addr] <= ld_inp2;
            mem_e[ld_addr] <= ld_expect;
        end
    end

    always_comb begin
        n_clamp  = (num_vectors > N_MAX) ? N_MAX : num_vectors;
        idx_nxt  = idx + CW'(1);
        slot     = idx[AW-1:0];
        slot_nxt = idx_nxt[AW-1:0];
        // A slot-0 write in the start cycle must reach the first request.
        ld_hit0  = ld_en && (ld_addr == '0);
        first_a  = ld_hit0 ? ld_inp1 : mem_a[0];
        first_b  = ld_hit0 ? ld_inp2 : mem_b[0];
        // A response on the expiry cycle wins over the timeout.
        vec_end  = rsp_valid || (timer == T_LAST);
        vec_fail = rsp_valid ? (rsp_result != mem_e[slot]) : 1'b1;
    end

    // Run sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            req_valid        <= 1'b0;
            req_inp1         <= '0;
            req_inp2         <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
            n_vec            <= '0;
            idx              <= '0;
            timer            <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_vec            <= n_clamp;
                        idx              <= '0;
                        pass_cnt         <= '0;
                        fail_cnt         <= '0;
                        first_fail_valid <= 1'b0;
                        busy             <= 1'b1;
                        if (n_clamp == '0) begin
                            state <= S_FIN;
                        end else begin
                            state     <= S_ISSUE;
                            req_valid <= 1'b1;
                            req_inp1  <= first_a;
                            req_inp2  <= first_b;
                        end
                    end
                end
                S_ISSUE: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        timer     <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (vec_end) begin
                        if (vec_fail) begin
                            fail_cnt <= sat_inc(fail_cnt);
                            if (!first_fail_valid) begin
                                first_fail_valid <= 1'b1;
                                first_fail_idx   <= slot;
                            end
                        end else begin
                            pass_cnt <= sat_inc(pass_cnt);
                        end
                        idx <= idx_nxt;
                        if (idx_nxt == n_vec) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_ISSUE;
                            req_valid <= 1'b1;
                            req_inp1  <= mem_a[slot_nxt];
                            req_inp2  <= mem_b[slot_nxt];
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_FIN: begin
                    // Entered from WAIT with done already raised; a zero-length
                    // run arrives with done low and raises it here first.
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_vector_initiator.sv
// Bench for mul_vector_initiator: responder model with programmable latency,
// stalls and dropped responses; per-run results predicted from the table.
module tb_mul_vector_initiator;

    logic        clk;
    logic        rst;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_inp1, ld_inp2, ld_expect;
    logic [4:0]  num_vectors;
    logic        start;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_inp1, req_inp2;
    logic        rsp_valid;
    logic [31:0] rsp_result;
    logic        busy, done;
    logic [4:0]  pass_cnt, fail_cnt;
    logic        first_fail_valid;
    logic [3:0]  first_fail_idx;

    mul_vector_initiator dut (
        .clk(clk), .rst(rst),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_inp1(ld_inp1), .ld_inp2(ld_inp2),
        .ld_expect(ld_expect), .num_vectors(num_vectors), .start(start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_inp1(req_inp1), .req_inp2(req_inp2),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] tbl_a [16];
    logic [31:0] tbl_b [16];
    logic [31:0] tbl_e [16];
    bit          drop  [16];

    int          cyc = 0;
    int          acc = 0;
    int          exp_evt = 0;
    bit          pend = 0;
    int          cnt = 0;
    logic [31:0] res = 0;
    bit          emitted = 0;
    int          stall_left = 0;
    int          done_seen = 0;
    int          done_cyc = 0;
    int          lat = 0;
    bit          rnd_ready = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Responder arithmetic: product with its result-equals-10 adjustment.
    function automatic logic [31:0] resp_fn(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] p;
        p = a * b;
        if (p == 32'd10) p = 32'd11;
        return p;
    endfunction

    // One clock: sample just after the edge, update responder, drive inputs.
    task automatic tick();
        bit          hs, rs, pv, rp;
        logic [31:0] pa, pb;
        int          cur;
        hs = req_valid && req_ready;
        rs = rsp_valid && emitted;
        pv = req_valid;
        rp = rst;
        pa = req_inp1;
        pb = req_inp2;
        cur = cyc;
        @(posedge clk);
        #1;
        cyc++;
        rsp_valid = 1'b0;
        emitted = 1'b0;
        if (hs) begin
            if (acc < 16) begin
                check("acc_op1", 64'(pa), 64'(tbl_a[acc]));
                check("acc_op2", 64'(pb), 64'(tbl_b[acc]));
                if (drop[acc]) begin
                    pend = 1'b0;
                    exp_evt = cur + 65;
                end else begin
                    pend = 1'b1;
                    cnt = lat;
                    res = resp_fn(pa, pb);
                end
            end
            acc++;
        end else if (pv && !rp) begin
            check("hold_valid", 64'(req_valid), 64'd1);
            check("hold_op1", 64'(req_inp1), 64'(pa));
            check("hold_op2", 64'(req_inp2), 64'(pb));
        end
        if (rs) exp_evt = cur + 1;
        if (acc > 0 && !rp && ((req_valid && !pv) || done))
            check("next_evt_cycle", 64'(cyc), 64'(exp_evt));
        if (done) begin
            done_seen++;
            done_cyc = cyc;
        end
        if (pend) begin
            if (cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_result = res;
                emitted = 1'b1;
                pend = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (stall_left > 0 && acc == 0 && req_valid) begin
            req_ready = 1'b0;
            stall_left--;
        end else begin
            req_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    endtask

    task automatic load(input int addr, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e);
        ld_en = 1'b1;
        ld_addr = 4'(addr);
        ld_inp1 = a;
        ld_inp2 = b;
        ld_expect = e;
        tbl_a[addr] = a;
        tbl_b[addr] = b;
        tbl_e[addr] = e;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic load_base();
        load(0, 32'd3, 32'd4, 32'd12);
        load(1, 32'd5, 32'd2, 32'd11);
        load(2, 32'd7, 32'd0, 32'd0);
        load(3, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE);
    endtask

    // Runs n vectors; optional slot-0 write in the start cycle.
    task automatic run(input int n, input int hold, input bit ld0,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] e0);
        int nc, ep, ef, efi, s, b;
        bit effv, any_valid;
        if (ld0) begin
            ld_en = 1'b1;
            ld_addr = 4'd0;
            ld_inp1 = a0;
            ld_inp2 = b0;
            ld_expect = e0;
            tbl_a[0] = a0;
            tbl_b[0] = b0;
            tbl_e[0] = e0;
        end
        nc = (n > 16) ? 16 : n;
        ep = 0; ef = 0; effv = 0; efi = 0;
        for (int i = 0; i < nc; i++) begin
            if (!drop[i] && resp_fn(tbl_a[i], tbl_b[i]) == tbl_e[i]) begin
                ep++;
            end else begin
                ef++;
                if (!effv) begin
                    effv = 1;
                    efi = i;
                end
            end
        end
        acc = 0;
        stall_left = hold;
        done_seen = 0;
        num_vectors = 5'(n);
        start = 1'b1;
        s = cyc;
        tick();
        start = 1'b0;
        ld_en = 1'b0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_req_valid", 64'(req_valid), 64'(nc > 0));
        if (nc > 0) begin
            check("start_op1", 64'(req_inp1), 64'(tbl_a[0]));
            check("start_op2", 64'(req_inp2), 64'(tbl_b[0]));
        end
        any_valid = req_valid;
        b = 0;
        while (done_seen == 0 && b < 6000) begin
            tick();
            any_valid |= req_valid;
            b++;
        end
        if (done_seen == 0) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("pass_cnt", 64'(pass_cnt), 64'(ep));
            check("fail_cnt", 64'(fail_cnt), 64'(ef));
            check("first_fail_valid", 64'(first_fail_valid), 64'(effv));
            if (effv) check("first_fail_idx", 64'(first_fail_idx), 64'(efi));
            if (nc == 0) begin
                check("zero_done_cycle", 64'(done_cyc), 64'(s + 2));
                check("zero_no_req", 64'(any_valid), 64'd0);
            end
        end
        check("accepts", 64'(acc), 64'(nc));
        tick();
        check("done_drop", 64'(done), 64'd0);
        check("busy_drop", 64'(busy), 64'd0);
        check("done_pulses", 64'(done_seen), 64'd1);
        check("pass_hold", 64'(pass_cnt), 64'(ep));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, 64'(req_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_op1"}, 64'(req_inp1), 64'd0);
        check({tag, "_op2"}, 64'(req_inp2), 64'd0);
        check({tag, "_pass"}, 64'(pass_cnt), 64'd0);
        check({tag, "_fail"}, 64'(fail_cnt), 64'd0);
        check({tag, "_ffv"}, 64'(first_fail_valid), 64'd0);
        check({tag, "_ffi"}, 64'(first_fail_idx), 64'd0);
    endtask

    initial begin
        int b;
        logic [31:0] ra, rb;
        rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_inp1 = '0; ld_inp2 = '0;
        ld_expect = '0; num_vectors = '0; start = 1'b0; req_ready = 1'b1;
        rsp_valid = 1'b0; rsp_result = '0;
        for (int i = 0; i < 16; i++) begin
            drop[i] = 0; tbl_a[i] = '0; tbl_b[i] = '0; tbl_e[i] = '0;
        end
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Full pass at latency 33.
        for (int i = 0; i < 16; i++) load(i, 32'(i), 32'd1, 32'(i));
        load_base();
        lat = 33;
        run(4, 0, 0, 0, 0, 0);

        // Expected value 10 for vector 1 mismatches the adjusted result.
        load(1, 32'd5, 32'd2, 32'd10);
        run(4, 0, 0, 0, 0, 0);
        load(1, 32'd5, 32'd2, 32'd11);

        // Ready held low for 20 cycles on vector 0.
        lat = 5;
        run(4, 20, 0, 0, 0, 0);

        // Vector 2 never answered.
        drop[2] = 1;
        run(4, 0, 0, 0, 0, 0);
        drop[2] = 0;

        // Zero-length run.
        run(0, 0, 0, 0, 0, 0);

        // Response on the timeout expiry cycle counts as a response.
        lat = 63;
        run(4, 0, 0, 0, 0, 0);

        // Spurious response while idle.
        rsp_valid = 1'b1;
        rsp_result = 32'd12;
        tick();
        check("spurious_pass", 64'(pass_cnt), 64'd4);
        check("spurious_fail", 64'(fail_cnt), 64'd0);
        check("spurious_busy", 64'(busy), 64'd0);

        // Slot-0 write in the start cycle reaches the first request.
        lat = 2;
        run(2, 0, 1, 32'd6, 32'd7, 32'd42);

        // Request count clamped to table depth.
        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom_range(0, 20);
            load(i, ra, rb, resp_fn(ra, rb));
        end
        lat = 1;
        run(20, 0, 0, 0, 0, 0);

        // Reset during WAIT of vector 1, then rerun.
        load_base();
        lat = 20;
        acc = 0;
        done_seen = 0;
        num_vectors = 5'd4;
        start = 1'b1;
        tick();
        start = 1'b0;
        b = 0;
        while (acc < 2 && b < 500) begin
            tick();
            b++;
        end
        check("reached_vec1", 64'(acc), 64'd2);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("midrun");
        for (int i = 0; i < 30; i++) tick();
        check("after_rst_done", 64'(done_seen), 64'd0);
        check("after_rst_pass", 64'(pass_cnt), 64'd0);
        check("after_rst_busy", 64'(busy), 64'd0);
        lat = 3;
        run(4, 0, 0, 0, 0, 0);

        // Randomized tables, lengths, latencies, drops and ready stalls.
        rnd_ready = 1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) begin
                ra = $urandom_range(0, 15); rb = $urandom;
                if ($urandom_range(0, 3) == 0)
                    load(i, ra, rb, resp_fn(ra, rb) ^ (32'd1 << $urandom_range(0, 31)));
                else
                    load(i, ra, rb, resp_fn(ra, rb));
                drop[i] = ($urandom_range(0, 9) == 0);
            end
            lat = $urandom_range(0, 40);
            run($urandom_range(0, 20), $urandom_range(0, 5), 0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
